// File: rtl/quantum_scheduler.sv
// Preemption / context-switch controller: counts retired user instructions and
// raises a switch request on quantum expiry, I/O (QSCHED_IO_PREEMPT_EN) or process end.
module quantum_scheduler #(
  parameter int PC_W    = 32,
  parameter int NPROC   = 8,
  parameter int PID_W   = 3,
  parameter int CNT_W   = 16,
  parameter int QUANTUM = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc,
  input  logic             pc_valid,
  input  logic             io_instr,
  input  logic             proc_end,
  input  logic [PID_W-1:0] proc_id,
  input  logic [NPROC-1:0] ready,
  input  logic             quantum_wr,
  input  logic [CNT_W-1:0] quantum_in,
  input  logic             switch_ack,
  output logic             ctx_req,
  output logic [1:0]       ctx_cause,
  output logic [PC_W-1:0]  saved_pc,
  output logic [PID_W-1:0] saved_pid,
  output logic [PID_W-1:0] next_pid,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {RUN, REQ} state_t;

  state_t           state_q, state_d;
  logic             ctx_req_q, ctx_req_d;
  logic [1:0]       cause_q, cause_d;
  logic [PC_W-1:0]  saved_pc_q, saved_pc_d;
  logic [PID_W-1:0] saved_pid_q, saved_pid_d;
  logic [PID_W-1:0] next_pid_q, next_pid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] quantum_q, quantum_d;

  logic             io_evt;
  logic             expire;
  logic [CNT_W:0]   count_inc;
  logic [PID_W-1:0] rr_pid;
  logic             rr_found;
  logic [NPROC-1:0] ready_shift;
  int               cand;

`ifdef QSCHED_IO_PREEMPT_EN
  assign io_evt = io_instr;
`else
  assign io_evt = io_instr & 1'b0;
`endif

  // ">=" rather than "==" so a quantum lowered below the count fires on the next instruction
  assign count_inc = {1'b0, count_q} + (CNT_W+1)'(1);
  assign expire    = (count_inc >= {1'b0, quantum_q});

  // Round-robin: ids after proc_id, wrap, skip 0; proc_id itself comes last and
  // is only eligible when it is not terminating.
  always_comb begin
    rr_pid      = '0;
    rr_found    = 1'b0;
    cand        = 0;
    ready_shift = '0;
    for (int k = 1; k <= NPROC; k++) begin
      cand        = (int'(proc_id) + k) % NPROC;
      ready_shift = ready >> cand;
      if (!rr_found && (cand != 0) && ready_shift[0] && ((k != NPROC) || !proc_end)) begin
        rr_found = 1'b1;
        rr_pid   = PID_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ctx_req_d   = ctx_req_q;
    cause_d     = cause_q;
    saved_pc_d  = saved_pc_q;
    saved_pid_d = saved_pid_q;
    next_pid_d  = next_pid_q;
    count_d     = count_q;
    quantum_d   = quantum_q;

    if (quantum_wr) begin
      quantum_d = (quantum_in == '0) ? CNT_W'(1) : quantum_in;
    end

    case (state_q)
      RUN: begin
        if (proc_id == '0) begin
          count_d = '0;
        end else if (pc_valid) begin
          if (proc_end || expire || io_evt) begin
            if (proc_end)    cause_d = 2'b11;
            else if (expire) cause_d = 2'b01;
            else             cause_d = 2'b10;
            saved_pc_d  = pc + PC_W'(1);
            saved_pid_d = proc_id;
            next_pid_d  = rr_pid;
            ctx_req_d   = 1'b1;
            count_d     = '0;
            state_d     = REQ;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      REQ: begin
        if (switch_ack) begin
          ctx_req_d = 1'b0;
          cause_d   = 2'b00;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      ctx_req_q   <= 1'b0;
      cause_q     <= 2'b00;
      saved_pc_q  <= '0;
      saved_pid_q <= '0;
      next_pid_q  <= '0;
      count_q     <= '0;
      quantum_q   <= CNT_W'(QUANTUM);
    end else begin
      state_q     <= state_d;
      ctx_req_q   <= ctx_req_d;
      cause_q     <= cause_d;
      saved_pc_q  <= saved_pc_d;
      saved_pid_q <= saved_pid_d;
      next_pid_q  <= next_pid_d;
      count_q     <= count_d;
      quantum_q   <= quantum_d;
    end
  end

  assign ctx_req   = ctx_req_q;
  assign ctx_cause = cause_q;
  assign saved_pc  = saved_pc_q;
  assign saved_pid = saved_pid_q;
  assign next_pid  = next_pid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed self-checking bench for quantum_scheduler (default 8 processes, quantum 10).
module tb_quantum_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        io_instr = 1'b0;
  logic        proc_end = 1'b0;
  logic [2:0]  proc_id = '0;
  logic [7:0]  ready = '0;
  logic        quantum_wr = 1'b0;
  logic [15:0] quantum_in = '0;
  logic        switch_ack = 1'b0;
  logic        ctx_req;
  logic [1:0]  ctx_cause;
  logic [31:0] saved_pc;
  logic [2:0]  saved_pid;
  logic [2:0]  next_pid;
  logic [15:0] count;

  int tests_run = 0;
  int tests_failed = 0;

  quantum_scheduler dut (
    .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid), .io_instr(io_instr),
    .proc_end(proc_end), .proc_id(proc_id), .ready(ready), .quantum_wr(quantum_wr),
    .quantum_in(quantum_in), .switch_ack(switch_ack), .ctx_req(ctx_req),
    .ctx_cause(ctx_cause), .saved_pc(saved_pc), .saved_pid(saved_pid),
    .next_pid(next_pid), .count(count)
  );

  always #5 clock = ~clock;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic retire(input logic [31:0] p, input logic io, input logic pend);
    pc = p; pc_valid = 1'b1; io_instr = io; proc_end = pend;
    tick();
    pc_valid = 1'b0; io_instr = 1'b0; proc_end = 1'b0;
  endtask

  task automatic retire_n(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) retire(base + 32'(i), 1'b0, 1'b0);
  endtask

  task automatic ack();
    switch_ack = 1'b1;
    tick();
    switch_ack = 1'b0;
    tests_run++; if (ctx_req !== 1'b0) begin tests_failed++; $display("FAIL ack_req got %0b want 0", ctx_req); end
    tests_run++; if (ctx_cause !== 2'b00) begin tests_failed++; $display("FAIL ack_cause got %b want 00", ctx_cause); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    tests_run++; if (ctx_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req got %0b want 0", ctx_req); end
    tests_run++; if (ctx_cause !== 2'b00) begin tests_failed++; $display("FAIL rst_cause got %b want 00", ctx_cause); end
    tests_run++; if (saved_pc !== 32'h0) begin tests_failed++; $display("FAIL rst_pc got %h want 0", saved_pc); end
    tests_run++; if ({saved_pid, next_pid} !== 6'h0) begin tests_failed++; $display("FAIL rst_pids got %0d/%0d want 0/0", saved_pid, next_pid); end
    tests_run++; if (count !== 16'h0) begin tests_failed++; $display("FAIL rst_count got %0d want 0", count); end
    reset = 1'b0;
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_quantum_expiry();
    do_reset();
    proc_id = 3'd2; ready = 8'b0000_1100;
    retire_n(32'h100, 9);
    tests_run++; if (count !== 16'd9) begin tests_failed++; $display("FAIL qe_count9 got %0d want 9", count); end
    tests_run++; if (ctx_req !== 1'b0) begin tests_failed++; $display("FAIL qe_early got %0b want 0", ctx_req); end
    retire(32'h109, 1'b0, 1'b0);
    tests_run++; if (ctx_req !== 1'b1) begin tests_failed++; $display("FAIL qe_req got %0b want 1", ctx_req); end
    tests_run++; if (ctx_cause !== 2'b01) begin tests_failed++; $display("FAIL qe_cause got %b want 01", ctx_cause); end
    tests_run++; if (saved_pc !== 32'h10A) begin tests_failed++; $display("FAIL qe_pc got %h want 10a", saved_pc); end
    tests_run++; if (saved_pid !== 3'd2) begin tests_failed++; $display("FAIL qe_spid got %0d want 2", saved_pid); end
    tests_run++; if (next_pid !== 3'd3) begin tests_failed++; $display("FAIL qe_npid got %0d want 3", next_pid); end
    tests_run++; if (count !== 16'd0) begin tests_failed++; $display("FAIL qe_count got %0d want 0", count); end
    ack();
    $display("[TB] test_quantum_expiry done");
  endtask

  task automatic test_round_robin();
    do_reset();
    proc_id = 3'd7; ready = 8'b0000_0011;
    retire_n(32'h0, 10);
    tests_run++; if (next_pid !== 3'd1) begin tests_failed++; $display("FAIL rr_wrap got %0d want 1", next_pid); end
    ack();
    ready = 8'b0000_0000;
    retire_n(32'h0, 10);
    tests_run++; if (ctx_req !== 1'b1 || next_pid !== 3'd0) begin tests_failed++; $display("FAIL rr_empty got req %0b pid %0d want 1/0", ctx_req, next_pid); end
    ack();
    // Only the running process is ready: eligible on quantum, not on termination.
    proc_id = 3'd3; ready = 8'b0000_1000;
    retire_n(32'h0, 10);
    tests_run++; if (next_pid !== 3'd3) begin tests_failed++; $display("FAIL rr_self_q got %0d want 3", next_pid); end
    ack();
    retire(32'h40, 1'b0, 1'b1);
    tests_run++; if (ctx_cause !== 2'b11 || next_pid !== 3'd0) begin tests_failed++; $display("FAIL rr_self_end got cause %b pid %0d want 11/0", ctx_cause, next_pid); end
    ack();
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_priority();
    do_reset();
    proc_id = 3'd2; ready = 8'b0000_1100;
    retire_n(32'h300, 9);
    retire(32'h309, 1'b1, 1'b1);
    tests_run++; if (ctx_req !== 1'b1 || ctx_cause !== 2'b11) begin tests_failed++; $display("FAIL pri_end got req %0b cause %b want 1/11", ctx_req, ctx_cause); end
    ack();
    retire_n(32'h300, 9);
    retire(32'h309, 1'b1, 1'b0);
    tests_run++; if (ctx_req !== 1'b1 || ctx_cause !== 2'b01) begin tests_failed++; $display("FAIL pri_quant got req %0b cause %b want 1/01", ctx_req, ctx_cause); end
    ack();
    retire_n(32'h300, 3);
    retire(32'h303, 1'b1, 1'b0);
`ifdef QSCHED_IO_PREEMPT_EN
    tests_run++; if (ctx_req !== 1'b1 || ctx_cause !== 2'b10) begin tests_failed++; $display("FAIL pri_io got req %0b cause %b want 1/10", ctx_req, ctx_cause); end
    tests_run++; if (saved_pc !== 32'h304) begin tests_failed++; $display("FAIL pri_io_pc got %h want 304", saved_pc); end
`else
    tests_run++; if (ctx_req !== 1'b0) begin tests_failed++; $display("FAIL pri_io_req got %0b want 0", ctx_req); end
    tests_run++; if (count !== 16'd4) begin tests_failed++; $display("FAIL pri_io_count got %0d want 4", count); end
`endif
    $display("[TB] test_priority done");
  endtask

  task automatic test_handshake();
    do_reset();
    proc_id = 3'd2; ready = 8'b0000_1100;
    retire_n(32'h200, 10);
    for (int i = 0; i < 5; i++) begin
      retire(32'h500 + 32'(i), 1'b1, 1'b1);
      tests_run++;
      if (ctx_req !== 1'b1 || ctx_cause !== 2'b01 || saved_pc !== 32'h20A || next_pid !== 3'd3 || count !== 16'd0) begin
        tests_failed++;
        $display("FAIL hs_hold%0d got req %0b cause %b pc %h npid %0d cnt %0d want 1/01/20a/3/0", i, ctx_req, ctx_cause, saved_pc, next_pid, count);
      end
    end
    ack();
    // Ack is already high in the first REQ cycle: one-cycle request.
    switch_ack = 1'b1;
    retire_n(32'h200, 10);
    tests_run++; if (ctx_req !== 1'b1) begin tests_failed++; $display("FAIL hs_min_req got %0b want 1", ctx_req); end
    tick();
    tests_run++; if (ctx_req !== 1'b0) begin tests_failed++; $display("FAIL hs_min_clr got %0b want 0", ctx_req); end
    switch_ack = 1'b0;
    retire_n(32'h600, 10);
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (ctx_req !== 1'b0 || saved_pc !== 32'h0 || ctx_cause !== 2'b00) begin tests_failed++; $display("FAIL hs_async_rst got req %0b pc %h cause %b want 0/0/00", ctx_req, saved_pc, ctx_cause); end
    reset = 1'b0;
    tick();
    $display("[TB] test_handshake done");
  endtask

  task automatic test_os_quantum();
    do_reset();
    proc_id = 3'd0; ready = 8'b1111_1110;
    retire_n(32'h0, 20);
    tests_run++; if (ctx_req !== 1'b0 || count !== 16'd0) begin tests_failed++; $display("FAIL os_idle got req %0b cnt %0d want 0/0", ctx_req, count); end
    proc_id = 3'd2;
    quantum_wr = 1'b1; quantum_in = 16'd0;
    tick();
    quantum_wr = 1'b0;
    retire(32'h10, 1'b0, 1'b0);
    tests_run++; if (ctx_req !== 1'b1 || ctx_cause !== 2'b01) begin tests_failed++; $display("FAIL q_zero got req %0b cause %b want 1/01", ctx_req, ctx_cause); end
    ack();
    quantum_wr = 1'b1; quantum_in = 16'd10;
    tick();
    quantum_wr = 1'b0;
    retire_n(32'h20, 5);
    quantum_wr = 1'b1; quantum_in = 16'd3;
    tick();
    quantum_wr = 1'b0;
    tests_run++; if (ctx_req !== 1'b0 || count !== 16'd5) begin tests_failed++; $display("FAIL q_low_pre got req %0b cnt %0d want 0/5", ctx_req, count); end
    retire(32'h25, 1'b0, 1'b0);
    tests_run++; if (ctx_req !== 1'b1 || ctx_cause !== 2'b01) begin tests_failed++; $display("FAIL q_low got req %0b cause %b want 1/01", ctx_req, ctx_cause); end
    ack();
    // Write and retire together: old quantum (3) is compared, so no request yet.
    quantum_wr = 1'b1; quantum_in = 16'd1;
    retire(32'h30, 1'b0, 1'b0);
    quantum_wr = 1'b0;
    tests_run++; if (ctx_req !== 1'b0 || count !== 16'd1) begin tests_failed++; $display("FAIL q_same got req %0b cnt %0d want 0/1", ctx_req, count); end
    retire(32'h31, 1'b0, 1'b0);
    tests_run++; if (ctx_req !== 1'b1) begin tests_failed++; $display("FAIL q_same_next got %0b want 1", ctx_req); end
    ack();
    $display("[TB] test_os_quantum done");
  endtask

  initial begin
    test_reset();
    test_quantum_expiry();
    test_round_robin();
    test_priority();
    test_handshake();
    test_os_quantum();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
